// File: rtl/harvard_mem_responder.sv
// harvard_mem_responder: behavioural instruction ROM + data RAM responder for a
// CPU under test, with an IDLE/RUN/HALTED run-control FSM and activity counters.
// The instruction ROM can only be preloaded while IDLE. Neither memory is
// cleared by reset.
// Optional feature macro: MEM_FAULT_EN. When defined, a sticky fault flag
// reports misaligned, out-of-window and read+write-collision accesses, and
// misaligned data writes are dropped.
module harvard_mem_responder #(
    parameter logic [31:0] INSTR_BASE = 32'hBFC00000,
    parameter logic [31:0] DATA_BASE  = 32'h00000000,
    parameter int          INSTR_AW   = 8,
    parameter int          DATA_AW    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instr_address,
    output logic [31:0]         instr_readdata,
    input  logic [31:0]         data_address,
    input  logic                data_write,
    input  logic                data_read,
    input  logic [31:0]         data_writedata,
    output logic [31:0]         data_readdata,
    input  logic                cpu_active,
    input  logic                load_en,
    input  logic [INSTR_AW-1:0] load_addr,
    input  logic [31:0]         load_data,
    output logic                halted,
    output logic                fault,
    output logic [15:0]         instr_fetch_count,
    output logic [15:0]         data_access_count
);

    localparam int INSTR_WORDS = 2 ** INSTR_AW;
    localparam int DATA_WORDS  = 2 ** DATA_AW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_reg;
    logic        halted_reg;
    logic [15:0] fetch_cnt_reg;
    logic [15:0] access_cnt_reg;

    logic [31:0] rom_mem [INSTR_WORDS];
    logic [31:0] ram_mem [DATA_WORDS];

    // Word offsets from each window base; both bases are word aligned, so the
    // byte-offset >> 2 equals the difference of the word-address fields.
    logic [29:0]         instr_word;
    logic [29:0]         data_word;
    logic                instr_in_win;
    logic                data_in_win;
    logic [INSTR_AW-1:0] instr_idx;
    logic [DATA_AW-1:0]  data_idx;
    logic                ram_we;

    assign instr_word   = instr_address[31:2] - INSTR_BASE[31:2];
    assign data_word    = data_address[31:2] - DATA_BASE[31:2];
    assign instr_in_win = (instr_word[29:INSTR_AW] == '0);
    assign data_in_win  = (data_word[29:DATA_AW] == '0);
    assign instr_idx    = instr_word[INSTR_AW-1:0];
    assign data_idx     = data_word[DATA_AW-1:0];

`ifdef MEM_FAULT_EN
    assign ram_we = data_write && data_in_win && (data_address[1:0] == 2'b00);
`else
    assign ram_we = data_write && data_in_win;
`endif

    // Combinational fetch: out-of-window fetches return a NOP (all zeros).
    always_comb begin
        instr_readdata = 32'h0;
        if (instr_in_win)
            instr_readdata = rom_mem[instr_idx];
    end

    // Combinational load: sees the pre-write word when a write hits the same cycle.
    always_comb begin
        data_readdata = 32'h0;
        if (data_read && data_in_win)
            data_readdata = ram_mem[data_idx];
    end

    // Instruction preload, accepted only while the CPU has not started.
    always_ff @(posedge clk) begin
        if (load_en && (state_reg == ST_IDLE))
            rom_mem[load_addr] <= load_data;
    end

    // Data RAM store port; out-of-window stores are silently dropped.
    always_ff @(posedge clk) begin
        if (ram_we)
            ram_mem[data_idx] <= data_writedata;
    end

    // Run-control FSM with saturating activity counters and registered halted flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            halted_reg     <= 1'b0;
            fetch_cnt_reg  <= 16'h0;
            access_cnt_reg <= 16'h0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cpu_active)
                        state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (fetch_cnt_reg != 16'hFFFF)
                        fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
                    if ((data_read || data_write) && (access_cnt_reg != 16'hFFFF))
                        access_cnt_reg <= access_cnt_reg + 16'd1;
                    if (!cpu_active) begin
                        state_reg  <= ST_HALTED;
                        halted_reg <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_reg <= ST_HALTED;
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

    assign halted            = halted_reg;
    assign instr_fetch_count = fetch_cnt_reg;
    assign data_access_count = access_cnt_reg;

`ifdef MEM_FAULT_EN
    logic fault_reg;
    logic fault_hit;

    assign fault_hit = ((data_read || data_write) &&
                        ((data_address[1:0] != 2'b00) || !data_in_win)) ||
                       (data_read && data_write) ||
                       ((state_reg == ST_RUN) && (instr_address[1:0] != 2'b00));

    // Sticky access-error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)
            fault_reg <= 1'b0;
        else if (fault_hit)
            fault_reg <= 1'b1;
    end

    assign fault = fault_reg;
`else
    // Byte-lane address bits carry no meaning when fault checking is off.
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^{instr_address[1:0], data_address[1:0]};
    assign fault = 1'b0;
`endif

endmodule

// File: doc/harvard_mem_responder.md
HARVARD_MEM_RESPONDER -- requirements
Module: harvard_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line:
- INSTR_BASE, 32'hBFC00000, byte address of instruction word 0.
- DATA_BASE, 32'h00000000, byte address of data word 0.
- INSTR_AW, 8, instruction ROM index width (2**INSTR_AW words).
- DATA_AW, 8, data RAM index width (2**DATA_AW words).
REQ-002 Ports SHALL be, one per line:
- clk, in, 1, single clock, all state updates on posedge.
- reset, in, 1, synchronous active-high reset.
- instr_address, in, 32, CPU instruction fetch byte address.
- instr_readdata, out, 32, fetched instruction word.
- data_address, in, 32, CPU data byte address.
- data_write, in, 1, data write strobe.
- data_read, in, 1, data read strobe.
- data_writedata, in, 32, store data.
- data_readdata, out, 32, load data.
- cpu_active, in, 1, CPU active flag.
- load_en, in, 1, instruction preload strobe.
- load_addr, in, INSTR_AW, preload word index.
- load_data, in, 32, preload word.
- halted, out, 1, sticky CPU-finished flag.
- fault, out, 1, sticky access-error flag.
- instr_fetch_count, out, 16, RUN cycles counted.
- data_access_count, out, 16, data accesses counted.
REQ-003 The block SHALL use one clock (clk) and a synchronous active-high reset (reset).

Function
REQ-004 instr_readdata SHALL be combinational: ROM[(instr_address-INSTR_BASE)>>2] when the offset is inside the ROM window, else 32'h0 (NOP).
REQ-005 data_readdata SHALL be combinational: RAM[(data_address-DATA_BASE)>>2] when data_read=1 and in window, else 32'h0.
REQ-006 When data_write=1 and data_address is in window, RAM SHALL be written at posedge; read data SHALL reflect it from the next cycle.
REQ-007 When data_read and data_write are both 1, the write SHALL occur and data_readdata SHALL return the pre-write word.
REQ-008 The FSM SHALL have states IDLE, RUN, HALTED: IDLE->RUN when cpu_active=1; RUN->HALTED when cpu_active=0; HALTED holds until reset.
REQ-009 In IDLE only, load_en=1 SHALL write load_data to ROM[load_addr] at posedge; load_en SHALL be ignored in RUN and HALTED.
REQ-010 halted SHALL be 1 exactly while the FSM is in HALTED, asserted the cycle after cpu_active falls.
REQ-011 instr_fetch_count SHALL increment once per cycle in RUN, saturating at 16'hFFFF.
REQ-012 data_access_count SHALL increment once per RUN cycle in which data_read or data_write is 1, saturating at 16'hFFFF.
REQ-013 Out-of-window data writes SHALL be dropped without RAM change.

Reset
REQ-014 Reset SHALL set state IDLE, halted=0, fault=0 and both counters to 0 on the posedge it is sampled, including mid-RUN.
REQ-015 Reset SHALL NOT clear ROM or RAM contents; preloaded programs survive reset.

Configuration
REQ-016 With MEM_FAULT_EN defined, fault SHALL set (sticky until reset) the cycle after any of: data_read/data_write with data_address[1:0]!=0, data access out of window, read and write both 1, instr_address[1:0]!=0 in RUN.
REQ-017 With MEM_FAULT_EN defined, misaligned data writes SHALL be dropped.
REQ-018 Without MEM_FAULT_EN, fault SHALL be tied 0 and address bits [1:0] SHALL be ignored.

Verification
REQ-019 IDLE, load (0,32'h2423000A),(1,32'h24610006); instr_address=BFC00000 -> 2423000A; BFC00004 -> 24610006; BFC00400 -> 0.
REQ-020 data_write addr 0x10 data DEADBEEF; next cycle data_read addr 0x10 -> data_readdata DEADBEEF; data_read=0 -> 0.
REQ-021 cpu_active=1 for 5 cycles with 2 data reads, then 0 -> halted=1 next cycle, instr_fetch_count=5, data_access_count=2.
REQ-022 MEM_FAULT_EN: data_write addr 0x13 data 1 -> fault=1 next cycle, RAM[4] unchanged; without macro -> fault=0, RAM[4]=1.
REQ-023 load_en=1 at index 0 data FFFFFFFF during RUN -> ROM[0] still 2423000A.
REQ-024 Reset while HALTED -> halted=0, counters 0, state IDLE, BFC00000 still reads 2423000A.
